// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRKWAIT
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake and status pulses of the UART receiver.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 brk;
    logic [3:0]           onum_bits;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, brk, onum_bits,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, brk, onum_bits,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with one-entry holding register and error pulses.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling per bit.
//
// state   | meaning
// IDLE    | line idle, waiting for falling edge
// START   | checking start bit at sample point
// DATA    | shifting in data bits, LSB first
// PAR     | checking parity bit
// STOP    | checking stop bit(s), delivering word
// BRKWAIT | break seen, waiting for line to return high
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_param_if.master bus
);
    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int P    = (PARITY != PAR_NONE) ? 1 : 0;

    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS);
    localparam logic [3:0] FIRST_STOP = 4'(DATA_BITS + P + 1);
    localparam logic [3:0] LAST_STOP  = 4'(DATA_BITS + P + STOP_BITS);

    state_t               state;
    logic                 rxs, rxs_q;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg, data_q;
    logic                 par_bit, par_bad, stop_bad;
    logic                 valid_q, fe_q, pe_q, ov_q, brk_q;
    logic                 samp, bit_val, bit_end, par_exp;

    uart_rx_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));

`ifdef UART_RX_MAJORITY_EN
    logic s_early, s_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            if (cnt == CW'(HALF - 1)) s_early <= rxs;
            if (cnt == CW'(HALF))     s_mid   <= rxs;
        end
    end

    assign samp    = (cnt == CW'(HALF + 1));
    assign bit_val = (s_early & s_mid) | (s_early & rxs) | (s_mid & rxs);
`else
    assign samp    = (cnt == CW'(HALF));
    assign bit_val = rxs;
`endif

    assign bit_end = (cnt == CW'(DIV - 1));
    assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rxs_q    <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            ov_q     <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            rxs_q <= rxs;
            fe_q  <= 1'b0;
            pe_q  <= 1'b0;
            ov_q  <= 1'b0;
            brk_q <= 1'b0;
            if (valid_q && bus.rx_ready) valid_q <= 1'b0;
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) bit_idx <= bit_idx + 1'b1;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rxs_q && !rxs) begin
                        state    <= START;
                        par_bit  <= 1'b0;
                        par_bad  <= 1'b0;
                        stop_bad <= 1'b0;
                    end
                end
                START: begin
                    if (samp) begin
                        state <= bit_val ? IDLE : DATA;
                        if (bit_val) bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (samp) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_DATA) state <= (P != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (samp) begin
                        par_bit <= bit_val;
                        par_bad <= (bit_val != par_exp);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (samp) begin
                        // An all-zero frame through the first stop bit is a break, not a word.
                        if (bit_idx == FIRST_STOP && !bit_val && shreg == '0 && !par_bit) begin
                            brk_q   <= 1'b1;
                            fe_q    <= 1'b1;
                            bit_idx <= '0;
                            state   <= BRKWAIT;
                        end else if (bit_idx == LAST_STOP) begin
                            fe_q    <= stop_bad | ~bit_val;
                            pe_q    <= par_bad;
                            bit_idx <= '0;
                            state   <= IDLE;
                            if (!valid_q || bus.rx_ready) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end else begin
                                ov_q <= 1'b1;
                            end
                        end else begin
                            stop_bad <= stop_bad | ~bit_val;
                        end
                    end
                end
                BRKWAIT: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = fe_q;
    assign bus.parity_err = pe_q;
    assign bus.overrun    = ov_q;
    assign bus.brk        = brk_q;
    assign bus.onum_bits  = bit_idx;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default-rate, fast-rate and even-parity instances.
module tb_uart_rx_param;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int DIV_DEF = 868;
    localparam int DIV_F   = 16;
    localparam int LAT_DEF = 8249 + MAJ;
    localparam int LAT_F   = 155 + MAJ;
    localparam int LAT_P   = 171 + MAJ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_def = 1'b1, rx_fast = 1'b1, rx_par = 1'b1;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if_def ();
    uart_rx_param_if #(.DATA_BITS(8)) if_fast ();
    uart_rx_param_if #(.DATA_BITS(8)) if_par ();

    uart_rx_param dut_def (.clk(clk), .rst(rst), .rx(rx_def), .bus(if_def));
    uart_rx_param #(.BAUD(6_250_000)) dut_fast (.clk(clk), .rst(rst), .rx(rx_fast), .bus(if_fast));
    uart_rx_param #(.BAUD(6_250_000), .PARITY(1)) dut_par (.clk(clk), .rst(rst), .rx(rx_par), .bus(if_par));

    int checks = 0;
    int errors = 0;

    logic [2:0] fe_w, pe_w, ov_w, brk_w, val_w;
    assign fe_w  = {if_par.frame_err,  if_fast.frame_err,  if_def.frame_err};
    assign pe_w  = {if_par.parity_err, if_fast.parity_err, if_def.parity_err};
    assign ov_w  = {if_par.overrun,    if_fast.overrun,    if_def.overrun};
    assign brk_w = {if_par.brk,        if_fast.brk,        if_def.brk};
    assign val_w = {if_par.rx_valid,   if_fast.rx_valid,   if_def.rx_valid};

    int   n_fe[3], n_pe[3], n_ov[3], n_brk[3], n_vr[3], n_vf[3];
    time  t_rise[3];
    logic [2:0] vprev = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fe_w[i])  n_fe[i]++;
            if (pe_w[i])  n_pe[i]++;
            if (ov_w[i])  n_ov[i]++;
            if (brk_w[i]) n_brk[i]++;
            if (val_w[i] && !vprev[i]) begin
                n_vr[i]++;
                t_rise[i] = $time - 5;
            end
            if (!val_w[i] && vprev[i]) n_vf[i]++;
            vprev[i] = val_w[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_def  = v;
            1:       rx_fast = v;
            default: rx_par  = v;
        endcase
    endtask

    // Frame bit 0 goes on the line first; called on a falling clock edge.
    task automatic send(input int sel, input logic [15:0] frame, input int nbits, input int div);
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, frame[i]);
            repeat (div) @(negedge clk);
        end
        set_rx(sel, 1'b1);
    endtask

    task automatic consume_fast();
        if_fast.rx_ready = 1'b1;
        @(negedge clk);
        if_fast.rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        time t0;
        int  s_fe, s_pe, s_ov, s_brk, s_vr, s_vf;

        if_def.rx_ready  = 1'b0;
        if_fast.rx_ready = 1'b0;
        if_par.rx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_valid", 32'(if_fast.rx_valid), 0);
        check("rst_data", 32'(if_fast.rx_data), 0);
        check("rst_bits", 32'(if_fast.onum_bits), 0);
        check("rst_pulses", 32'(n_fe[1] + n_pe[1] + n_ov[1] + n_brk[1]), 0);

        // Default rate: 0x53 after 200 us idle.
        repeat (20000) @(negedge clk);
        s_fe = n_fe[0]; s_pe = n_pe[0]; s_brk = n_brk[0]; s_ov = n_ov[0];
        t0 = $time + 5;
        send(0, 16'({1'b1, 8'h53, 1'b0}), 10, DIV_DEF);
        check("def_data", 32'(if_def.rx_data), 32'h53);
        check("def_valid", 32'(if_def.rx_valid), 1);
        check("def_latency", 32'((t_rise[0] - t0) / 10), LAT_DEF);
        check("def_no_err", 32'((n_fe[0] - s_fe) + (n_pe[0] - s_pe) + (n_brk[0] - s_brk) + (n_ov[0] - s_ov)), 0);
        if_def.rx_ready = 1'b1;
        @(negedge clk);
        if_def.rx_ready = 1'b0;
        check("def_consumed", 32'(if_def.rx_valid), 0);

        // Glitch shorter than half a bit is a false start.
        s_vr = n_vr[0];
        rx_def = 1'b0;
        repeat (200) @(negedge clk);
        rx_def = 1'b1;
        repeat (900) @(negedge clk);
        check("glitch_novalid", 32'(n_vr[0] - s_vr), 0);
        check("glitch_idle_bits", 32'(if_def.onum_bits), 0);
        send(0, 16'({1'b1, 8'h3C, 1'b0}), 10, DIV_DEF);
        check("glitch_next_data", 32'(if_def.rx_data), 32'h3C);
        check("glitch_next_valid", 32'(n_vr[0] - s_vr), 1);
        if_def.rx_ready = 1'b1;
        @(negedge clk);
        if_def.rx_ready = 1'b0;

        // Fast rate latency.
        t0 = $time + 5;
        send(1, 16'({1'b1, 8'h5A, 1'b0}), 10, DIV_F);
        check("fast_data", 32'(if_fast.rx_data), 32'h5A);
        check("fast_latency", 32'((t_rise[1] - t0) / 10), LAT_F);
        consume_fast();

        // Overrun: second word discarded while first is unread.
        s_ov = n_ov[1];
        send(1, 16'({1'b1, 8'h11, 1'b0}), 10, DIV_F);
        send(1, 16'({1'b1, 8'h22, 1'b0}), 10, DIV_F);
        check("ovr_data_kept", 32'(if_fast.rx_data), 32'h11);
        check("ovr_valid", 32'(if_fast.rx_valid), 1);
        check("ovr_pulse", 32'(n_ov[1] - s_ov), 1);
        consume_fast();
        check("ovr_consumed", 32'(if_fast.rx_valid), 0);

        // Read in the completion cycle: new word replaces old, valid never drops.
        send(1, 16'({1'b1, 8'h11, 1'b0}), 10, DIV_F);
        s_ov = n_ov[1]; s_vf = n_vf[1];
        fork
            send(1, 16'({1'b1, 8'h22, 1'b0}), 10, DIV_F);
            begin
                repeat (LAT_F) @(negedge clk);
                if_fast.rx_ready = 1'b1;
                @(negedge clk);
                if_fast.rx_ready = 1'b0;
            end
        join
        check("swap_data", 32'(if_fast.rx_data), 32'h22);
        check("swap_no_ovr", 32'(n_ov[1] - s_ov), 0);
        check("swap_valid_held", 32'(n_vf[1] - s_vf), 0);
        consume_fast();

        // Stop bit low on non-zero data: word delivered with frame error.
        s_fe = n_fe[1]; s_brk = n_brk[1]; s_vr = n_vr[1];
        send(1, 16'({1'b0, 8'h55, 1'b0}), 10, DIV_F);
        repeat (32) @(negedge clk);
        check("ferr_data", 32'(if_fast.rx_data), 32'h55);
        check("ferr_pulse", 32'(n_fe[1] - s_fe), 1);
        check("ferr_no_brk", 32'(n_brk[1] - s_brk), 0);
        check("ferr_valid", 32'(n_vr[1] - s_vr), 1);
        consume_fast();

        // Break: line low for 20 bit times.
        s_fe = n_fe[1]; s_brk = n_brk[1]; s_vr = n_vr[1];
        rx_fast = 1'b0;
        repeat (20 * DIV_F) @(negedge clk);
        rx_fast = 1'b1;
        repeat (40) @(negedge clk);
        check("brk_pulse", 32'(n_brk[1] - s_brk), 1);
        check("brk_ferr", 32'(n_fe[1] - s_fe), 1);
        check("brk_novalid", 32'(n_vr[1] - s_vr), 0);
        send(1, 16'({1'b1, 8'h7E, 1'b0}), 10, DIV_F);
        check("brk_next_data", 32'(if_fast.rx_data), 32'h7E);

        // Reset in the middle of data bit 4 while 0x7E is still held.
        send(1, 16'({1'b1, 8'h53, 1'b0}), 4, DIV_F);
        rx_fast = 1'b0;
        repeat (DIV_F / 2) @(negedge clk);
        check("prerst_bits", 32'(if_fast.onum_bits), 4);
        check("prerst_valid", 32'(if_fast.rx_valid), 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(if_fast.rx_valid), 0);
        check("midrst_data", 32'(if_fast.rx_data), 0);
        check("midrst_bits", 32'(if_fast.onum_bits), 0);
        rx_fast = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        s_fe = n_fe[1];
        send(1, 16'({1'b1, 8'h53, 1'b0}), 10, DIV_F);
        check("postrst_data", 32'(if_fast.rx_data), 32'h53);
        check("postrst_valid", 32'(if_fast.rx_valid), 1);
        check("postrst_no_ferr", 32'(n_fe[1] - s_fe), 0);

        // Even parity: 0xA5 has four ones, so parity bit 1 is wrong.
        s_pe = n_pe[2]; s_fe = n_fe[2];
        t0 = $time + 5;
        send(2, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, DIV_F);
        check("par_bad_data", 32'(if_par.rx_data), 32'hA5);
        check("par_bad_pulse", 32'(n_pe[2] - s_pe), 1);
        check("par_bad_no_ferr", 32'(n_fe[2] - s_fe), 0);
        check("par_latency", 32'((t_rise[2] - t0) / 10), LAT_P);
        if_par.rx_ready = 1'b1;
        @(negedge clk);
        if_par.rx_ready = 1'b0;
        // 0x07 has three ones, parity bit 1 is correct.
        s_pe = n_pe[2];
        send(2, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, DIV_F);
        check("par_ok_data", 32'(if_par.rx_data), 32'h07);
        check("par_ok_no_pulse", 32'(n_pe[2] - s_pe), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, next generation of the team's fixed 8N1 `serial` receiver. Converts an asynchronous serial line into parallel words with configurable baud, data width, parity and stop bits. Delivers each word through a one-entry valid/ready holding register and reports framing, parity, overrun and break conditions. Sits between the board RX pin and the command decoder feeding the 7-segment display logic.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115200: line rate. `DIV = round(CLK_HZ/BAUD)` clocks per bit (868 at defaults); `HALF = DIV/2`.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  DATA_BITS  received word, valid while `rx_valid`.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts word when high with `rx_valid`.
- `frame_err`  out  1  one-cycle pulse: a stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (always 0 when `PARITY`=0).
- `overrun`  out  1  one-cycle pulse: frame completed while holding register full and not being read.
- `brk`  out  1  one-cycle pulse: break detected.
- `onum_bits`  out  4  index of bit currently being received (0 = start, 1..DATA_BITS = data), for debug.

## Operation
- `rx` passes through a 2-FF synchronizer (reset to 1); all logic uses the synchronized value `rxs`.
- States: IDLE, START, DATA, PAR, STOP, BRKWAIT.
- IDLE: on `rxs` falling (previous 1, current 0), clear bit counter `cnt`, go START.
- START: at sample point, if bit reads 1 → false start, return IDLE, no output. If 0 → DATA.
- DATA: one bit per DIV clocks, shifted in LSB first; after DATA_BITS bits → PAR if `PARITY`≠0, else STOP.
- PAR: sample parity bit, compare against XOR of data (even) or its inverse (odd).
- STOP: sample STOP_BITS stop bits. After the last one: load holding register, issue error pulses, return IDLE immediately (mid-stop-bit) so back-to-back frames resynchronise on the next start edge.
- Frame error: any stop bit sampled 0. Word is still delivered, flagged by `frame_err`.
- Break: all data bits 0, parity (if any) 0, and first stop bit 0 → pulse `brk` and `frame_err`, deliver no word, go BRKWAIT; leave to IDLE only after `rxs`=1.
- Holding register: loaded on frame completion when empty, or when full and `rx_ready`=1 in the same cycle (old word consumed, new loaded, `rx_valid` stays 1, no overrun). Full and not read → new word discarded, old kept, `overrun` pulses.
- `rx_valid` clears on `rx_valid && rx_ready` with no simultaneous load.
- Reset at any time, including mid-frame: state IDLE, all outputs 0, `rx_data`=0, synchronizer 1. No partial word survives.

## Timing
- Bit counter `cnt` runs 0..DIV-1 per bit and is cleared at the detected falling edge. The sample point is `cnt`=HALF.
- Decision at the sample point; next bit boundary at `cnt`=DIV-1.
- `rx_valid`, `rx_data` and the error pulses update on the clock edge following the last stop-bit decision.
- Latency from `rx` falling edge to `rx_valid` is `(1+DATA_BITS+P+STOP_BITS-1)*DIV + HALF + 3` clocks, where P is 1 when parity is enabled and 0 otherwise. The 3 clocks are 2 synchronizer clocks plus 1 output register clock.
- Error and `overrun` pulses are exactly one cycle wide.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit takes three samples at `cnt`=HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority, decided at HALF+1, so every decision and the output shift one clock later.
- `UART_RX_MAJORITY_EN` undefined: single sample at HALF.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum;
  - parity mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - a constant function computing DIV with rounding.
- Sub-module `uart_rx_sync`: 2-FF synchronizer with reset value 1.

## Test plan
- Defaults, send 0x53 8N1 after 200 us idle → `rx_data`=0x53, `rx_valid` rises 8249 clocks after the start edge (8250 with majority), no error pulses.
- `PARITY`=1, send 0xA5 with wrong parity bit 1 → `rx_data`=0xA5 delivered and `parity_err` pulses once.
- Glitch: `rx` low for 200 clocks then high → no `rx_valid`, FSM back in IDLE, next byte 0x3C received correctly.
- Hold `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_data` stays 0x11, `overrun` pulses at the second frame end. Repeat with `rx_ready`=1 in the completion cycle → 0x22 loaded, no overrun.
- `rx` held low for 20 bit times → single `brk` and `frame_err` pulse, no `rx_valid`; after `rx` returns high, 0x7E received correctly.
- Assert `rst` mid-data-bit 4 of a frame → all outputs 0 immediately. After release, the line idles high and the next 0x53 is received correctly.
